// File: rtl/ones_expand.sv
// ones_expand: turns a count into a WIDTH-bit thermometer mask and streams that
// mask out LSB first, one bit per ready/valid beat, WIDTH beats per frame.
// Optional self-check: define ONES_EXPAND_CHECK_EN to count emitted ones and
// flag a sticky chk_err when a frame's ones total disagrees with its count.
module ones_expand #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic [WIDTH-1:0] mask,
  output logic             busy,
  output logic             chk_err
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    idx_q;
  logic             out_bit_q;
  logic             out_last_q;
  logic [WIDTH-1:0] mask_q;

  logic [CW-1:0]    cnt_sat_d;
  logic [WIDTH-1:0] mask_d;
  logic [CW-1:0]    idx_d;
  logic             accept_c;
  logic             beat_c;

  assign accept_c = in_valid && (state_q == S_IDLE);
  assign beat_c   = out_ready && (state_q == S_SEND);
  assign idx_d    = idx_q + CW'(1);

  // Saturate the requested count and build its thermometer mask
  always_comb begin
    cnt_sat_d = (in_count > CNT_MAX) ? CNT_MAX : in_count;
    mask_d    = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      mask_d[i] = (CW'(i) < cnt_sat_d);
    end
  end

  // Frame FSM: accept a count in IDLE, emit WIDTH beats in SEND
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      out_bit_q  <= 1'b0;
      out_last_q <= 1'b0;
      mask_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_q    <= S_SEND;
            cnt_q      <= cnt_sat_d;
            idx_q      <= '0;
            mask_q     <= mask_d;
            out_bit_q  <= (cnt_sat_d != '0);
            out_last_q <= (LAST_IDX == '0);
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q    <= S_IDLE;
              idx_q      <= '0;
              out_bit_q  <= 1'b0;
              out_last_q <= 1'b0;
            end else begin
              idx_q      <= idx_d;
              out_bit_q  <= (idx_d < cnt_q);
              out_last_q <= (idx_d == LAST_IDX);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_SEND);
  assign busy      = (state_q == S_SEND);
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;
  assign mask      = mask_q;

`ifdef ONES_EXPAND_CHECK_EN
  logic [CW-1:0] ones_q;
  logic          chk_err_q;

  // Count ones actually emitted and compare against cnt at frame end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ones_q    <= '0;
      chk_err_q <= 1'b0;
    end else if (accept_c) begin
      ones_q <= '0;
    end else if (beat_c) begin
      if (out_bit_q) begin
        ones_q <= ones_q + CW'(1);
      end
      if (out_last_q && ((ones_q + CW'(out_bit_q)) != cnt_q)) begin
        chk_err_q <= 1'b1;
      end
    end
  end

  assign chk_err = chk_err_q;
`else
  logic unused_c;
  assign unused_c = accept_c ^ beat_c;
  assign chk_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ones_expand.sv
// Scoreboard bench for ones_expand: the driver queues the expected beats of each
// frame, an independent negedge monitor checks every presented beat.
module tb_ones_expand;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CW    = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    in_count;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic             out_last;
  logic [WIDTH-1:0] mask;
  logic             busy;
  logic             chk_err;

  typedef struct packed {
    logic b;
    logic l;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    rmode = 0;
  bit    idle_chk = 1'b0;

  ones_expand #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_count (in_count),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bit  (out_bit),
    .out_last (out_last),
    .mask     (mask),
    .busy     (busy),
    .chk_err  (chk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // out_ready: 0 = always 1, 1 = pattern 1,0,0,1, 2 = random
  initial begin
    int k;
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    k = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1:       out_ready = pat[k % 4];
        2:       out_ready = 1'($urandom);
        default: out_ready = 1'b1;
      endcase
      k++;
    end
  end

  // Monitor: compare presented beats (including stalled ones) to queue head
  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      if (idle_chk) begin
        check("in_ready_after_last", 32'(in_ready), 32'd1);
        idle_chk = 1'b0;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q[0];
          check("out_bit", 32'(out_bit), 32'(e.b));
          check("out_last", 32'(out_last), 32'(e.l));
          check("in_ready_in_send", 32'(in_ready), 32'd0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (e.l) begin
              idle_chk = 1'b1;
              check("chk_err", 32'(chk_err), 32'd0);
            end
          end
        end
      end
    end
  end

  // Offer a count (caller sits away from posedge); queue the frame from the mask
  task automatic send_count(input int c, input logic [WIDTH-1:0] exp_mask);
    int k;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("accept_wait", 32'(in_ready), 32'd1);
    for (int i = 0; i < int'(WIDTH); i++) begin
      exp_q.push_back('{b: exp_mask[i], l: (i == int'(WIDTH) - 1)});
    end
    in_valid = 1'b1;
    in_count = CW'(c);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_count = CW'($urandom);
    check("mask_after_accept", 32'(mask), 32'(exp_mask));
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Wait for the frame to drain, then confirm the mask held
  task automatic wait_idle(input logic [WIDTH-1:0] exp_mask);
    int k;
    k = 0;
    while (!(in_ready && exp_q.size() == 0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("frame_done", 32'(k < 400), 32'd1);
    @(negedge clk);
    check("mask_hold", 32'(mask), 32'(exp_mask));
  endtask

  function automatic logic [WIDTH-1:0] model_mask(input int c);
    int s;
    logic [31:0] m;
    s = (c > int'(WIDTH)) ? int'(WIDTH) : c;
    m = (32'd1 << s) - 32'd1;
    return m[WIDTH-1:0];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [WIDTH-1:0] m;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_count = '0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bit", 32'(out_bit), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mask", 32'(mask), 32'd0);
    check("rst_chk_err", 32'(chk_err), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Basic frame, accepted on the first edge after reset release
    send_count(5, 16'h001F);
    wait_idle(16'h001F);
    // Boundaries: all zeros, all ones, saturation
    send_count(0, 16'h0000);
    wait_idle(16'h0000);
    send_count(16, 16'hFFFF);
    wait_idle(16'hFFFF);
    send_count(31, 16'hFFFF);
    wait_idle(16'hFFFF);
    send_count(17, 16'hFFFF);
    wait_idle(16'hFFFF);
    send_count(1, 16'h0001);
    wait_idle(16'h0001);
    send_count(15, 16'h7FFF);
    wait_idle(16'h7FFF);

    // Stalled frame with an ignored count offered mid-frame
    rmode = 1;
    send_count(3, 16'h0007);
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    in_count = 5'd9;
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle(16'h0007);
    rmode = 0;

    // Reset abort at beat 7 of a 12-count frame
    send_count(12, 16'h0FFF);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_mask", 32'(mask), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send_count(2, 16'h0003);
    wait_idle(16'h0003);

    // Random counts with random back-pressure
    rmode = 2;
    for (int i = 0; i < 50; i++) begin
      c = int'($urandom_range(0, 31));
      m = model_mask(c);
      send_count(c, m);
      wait_idle(m);
    end
    rmode = 0;
    repeat (4) @(negedge clk);
    check("final_chk_err", 32'(chk_err), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ones_expand.md
ONES_EXPAND -- requirements
Module: ones_expand

Interface
- REQ-001: Parameter WIDTH, default 16: number of bits in the expanded word and serial frame.
- REQ-002: Parameter CW, default 5: width of the count input; SHALL satisfy 2**CW > WIDTH.
- REQ-003: clk  input  1  single clock; all state SHALL update on posedge clk.
- REQ-004: reset  input  1  asynchronous, active-high reset.
- REQ-005: in_valid  input  1  count word offered.
- REQ-006: in_ready  output  1  block can accept a count.
- REQ-007: in_count  input  CW  requested number of ones.
- REQ-008: out_valid  output  1  serial bit valid.
- REQ-009: out_ready  input  1  sink accepts serial bit.
- REQ-010: out_bit  output  1  current serial bit, LSB of frame first.
- REQ-011: out_last  output  1  current bit is frame bit WIDTH-1.
- REQ-012: mask  output  WIDTH  registered thermometer mask of the last accepted count.
- REQ-013: busy  output  1  frame in progress.
- REQ-014: chk_err  output  1  sticky self-check error flag (see Configuration).

Function
- REQ-015: FSM SHALL have two states, IDLE and SEND; in_ready SHALL be 1 exactly in IDLE, busy and out_valid exactly in SEND.
- REQ-016: Accept occurs when in_valid && in_ready; the block SHALL latch cnt = min(in_count, WIDTH), set bit index idx = 0, load mask with ones in bits [cnt-1:0] and zeros above, and enter SEND on the next edge.
- REQ-017: First out_valid SHALL assert the cycle after acceptance (latency 1).
- REQ-018: In SEND, out_bit SHALL equal (idx < cnt) and out_last SHALL equal (idx == WIDTH-1).
- REQ-019: On out_valid && out_ready, idx SHALL increment; with out_ready low, out_bit, out_last and idx SHALL hold.
- REQ-020: On the handshake where out_last is 1, FSM SHALL return to IDLE; in_ready SHALL rise the following cycle, never the same cycle (no back-to-back accept in one cycle).
- REQ-021: Every frame SHALL be exactly WIDTH beats, including cnt = 0 (all zeros) and cnt = WIDTH (all ones).
- REQ-022: in_count > WIDTH SHALL saturate to WIDTH.
- REQ-023: in_count and in_valid SHALL be ignored while in SEND.
- REQ-024: mask SHALL hold its value from acceptance until the next acceptance, independent of FSM state.
- REQ-025: Total ones emitted per frame SHALL equal cnt; the ones SHALL be contiguous starting at beat 0.

Reset
- REQ-026: reset high SHALL, without waiting for clk, force state IDLE, idx = 0, cnt = 0, mask = 0, chk_err = 0.
- REQ-027: Under reset: in_ready = 1, out_valid = 0, out_bit = 0, out_last = 0, busy = 0.
- REQ-028: reset asserted mid-frame SHALL abort the frame; no further beats of it SHALL be emitted after release.
- REQ-029: First acceptance SHALL be possible on the first clk edge after reset deasserts.

Configuration
- REQ-030: Macro ONES_EXPAND_CHECK_EN, when defined, SHALL add a CW-bit counter of ones emitted (incremented on each handshaked beat with out_bit = 1, cleared at acceptance) and, on the out_last handshake, set chk_err if (counter + out_bit) != cnt; chk_err SHALL stay set until reset.
- REQ-031: Without ONES_EXPAND_CHECK_EN, chk_err SHALL be tied to 0 and no check counter SHALL exist; all other behaviour SHALL be identical.

Verification
- REQ-032: Reset, then in_count=5, out_ready=1 -> mask=16'h001F next cycle; out_bit 1 for beats 0..4, 0 for 5..15; out_last on beat 15; in_ready 1 cycle after.
- REQ-033: in_count=0 then in_count=16 -> frame of 16 zeros, then 16 ones; mask 16'h0000 then 16'hFFFF.
- REQ-034: in_count=31 -> saturates: mask=16'hFFFF, 16 ones emitted, no 17th beat.
- REQ-035: in_count=3, out_ready toggled 1,0,0,1,... -> out_bit/out_last stable during stalls; exactly 3 ones across 16 handshakes; in_valid pulsed with in_count=9 during SEND ignored.
- REQ-036: Assert reset at beat 7 of in_count=12 frame -> out_valid=0, mask=0, in_ready=1 immediately; after release in_count=2 -> clean frame with 2 ones.
- REQ-037: With ONES_EXPAND_CHECK_EN, 50 random counts 0..31 with random out_ready -> chk_err stays 0; without the macro chk_err constant 0.
